// File: rtl/mem_xfer_engine_if.sv
// Control, status and memory-port bundle for mem_xfer_engine.
// master = engine side, slave = controller / memory side.
interface mem_xfer_engine_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   // start is a request pulse honoured only while busy is low; done pulses for one
   // cycle at completion. rd_cs/wr_cs are single-cycle strobes with no back-pressure.
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [ADDR_W-1:0] len;
   logic [1:0]        mode;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [DATA_W-1:0] sum;
   logic              rd_cs;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_cs;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        fsm_state;

   modport master (
      input  start, abort, src_base, dst_base, len, mode, rd_data,
      output busy, done, aborted, sum, rd_cs, rd_addr, wr_cs, wr_addr, wr_data, fsm_state
   );

   modport slave (
      output start, abort, src_base, dst_base, len, mode, rd_data,
      input  busy, done, aborted, sum, rd_cs, rd_addr, wr_cs, wr_addr, wr_data, fsm_state
   );
endinterface

// File: rtl/mem_xfer_engine.sv
// Memory sweep engine: reads a source window, accumulates a running sum and
// writes mode-transformed data to a destination window.
module mem_xfer_engine #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   mem_xfer_engine_if.master  bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;
   localparam int HALF = DATA_W / 2;
   localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        state;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W:0]   n_q;
   logic [ADDR_W:0]   cnt;
   logic [1:0]        mode_q;
   logic              aborted_q;
   logic              wr_cs_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [DATA_W-1:0] sum_q;
   logic [DATA_W-1:0] xform;
   logic [RD_LAT-1:0] vld_pipe;
   logic [ADDR_W-1:0] off_pipe [RD_LAT];
   logic              issue;
   logic              last_rd;
   logic              ret_vld;

   // A cycle with abort high in ISSUE issues no read.
   assign issue   = (state == ISSUE) && !bus.abort;
   assign last_rd = issue && (cnt == n_q - ONE);
   assign ret_vld = vld_pipe[RD_LAT-1];

   always_comb begin
      xform = bus.rd_data;
      case (mode_q)
         2'b01:   xform = {bus.rd_data[HALF-1:0], bus.rd_data[HALF-1:0]};
         2'b10:   xform = ~bus.rd_data;
         default: xform = bus.rd_data;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         n_q       <= '0;
         cnt       <= '0;
         mode_q    <= '0;
         aborted_q <= 1'b0;
         wr_cs_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         sum_q     <= '0;
         vld_pipe  <= '0;
         for (int i = 0; i < RD_LAT; i++) off_pipe[i] <= '0;
      end else begin
         // Offset travels alongside its valid bit so the write lands at dst_base+offset.
         vld_pipe[0] <= issue;
         off_pipe[0] <= cnt[ADDR_W-1:0];
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            off_pipe[i] <= off_pipe[i-1];
         end

         wr_cs_q <= ret_vld && (mode_q != 2'b11);
         if (ret_vld) begin
            sum_q <= sum_q + bus.rd_data;
            if (mode_q != 2'b11) begin
               wr_addr_q <= dst_q + off_pipe[RD_LAT-1];
               wr_data_q <= xform;
            end
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  src_q     <= bus.src_base;
                  dst_q     <= bus.dst_base;
                  mode_q    <= bus.mode;
                  n_q       <= (bus.len == '0) ? FULL : {1'b0, bus.len};
                  cnt       <= '0;
                  sum_q     <= '0;
                  aborted_q <= 1'b0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.abort) begin
                  aborted_q <= 1'b1;
                  state     <= DRAIN;
               end else begin
                  cnt <= cnt + ONE;
                  if (last_rd) state <= DRAIN;
               end
            end
            // Empty pipeline means the final write was registered and is on the bus now.
            DRAIN:   if (vld_pipe == '0) state <= FINISH;
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state == ISSUE) || (state == DRAIN);
   assign bus.done      = (state == FINISH);
   assign bus.aborted   = aborted_q;
   assign bus.sum       = sum_q;
   assign bus.rd_cs     = issue;
   assign bus.rd_addr   = src_q + cnt[ADDR_W-1:0];
   assign bus.wr_cs     = wr_cs_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.fsm_state = state;
endmodule

// File: tb/tb_mem_xfer_engine.sv
// Scoreboard bench for mem_xfer_engine: one instance with read latency 1 and one with 3,
// each fed by a shared source memory model.
module tb_mem_xfer_engine;
   localparam int AW = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_seen [2] = '{0, 0};

   logic [DW-1:0] src_mem [64];
   logic [DW-1:0] rp1;
   logic [DW-1:0] rp3 [3];

   // rd: {cycle, addr}; wr: {cycle, addr, data}; dn: {cycle, aborted, sum}
   logic [21:0] exp_rd1 [$];
   logic [21:0] exp_rd3 [$];
   logic [53:0] exp_wr1 [$];
   logic [53:0] exp_wr3 [$];
   logic [48:0] exp_dn1 [$];
   logic [48:0] exp_dn3 [$];

   mem_xfer_engine_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
   mem_xfer_engine_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

   mem_xfer_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
   mem_xfer_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3));

   // ---------------- clock / reset / memory models ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      rp1    <= b1.rd_cs ? src_mem[b1.rd_addr] : 32'hDEAD_BEEF;
      rp3[0] <= b3.rd_cs ? src_mem[b3.rd_addr] : 32'hDEAD_BEEF;
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
   end
   assign b1.rd_data = rp1;
   assign b3.rd_data = rp3[2];

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] xf(input logic [1:0] md, input logic [DW-1:0] d);
      case (md)
         2'b01:   return {d[15:0], d[15:0]};
         2'b10:   return ~d;
         default: return d;
      endcase
   endfunction

   task automatic drive(input bit l3, input logic st, input logic ab, input logic [5:0] sb,
                        input logic [5:0] db, input logic [5:0] ln, input logic [1:0] md);
      if (l3) begin
         b3.start = st; b3.abort = ab; b3.src_base = sb; b3.dst_base = db; b3.len = ln; b3.mode = md;
      end else begin
         b1.start = st; b1.abort = ab; b1.src_base = sb; b1.dst_base = db; b1.len = ln; b1.mode = md;
      end
   endtask

   task automatic chk_idle(input bit l3, input string p);
      check({p, " busy"},    64'(l3 ? b3.busy    : b1.busy),    64'd0);
      check({p, " done"},    64'(l3 ? b3.done    : b1.done),    64'd0);
      check({p, " aborted"}, 64'(l3 ? b3.aborted : b1.aborted), 64'd0);
      check({p, " rd_cs"},   64'(l3 ? b3.rd_cs   : b1.rd_cs),   64'd0);
      check({p, " wr_cs"},   64'(l3 ? b3.wr_cs   : b1.wr_cs),   64'd0);
      check({p, " rd_addr"}, 64'(l3 ? b3.rd_addr : b1.rd_addr), 64'd0);
      check({p, " wr_addr"}, 64'(l3 ? b3.wr_addr : b1.wr_addr), 64'd0);
      check({p, " wr_data"}, 64'(l3 ? b3.wr_data : b1.wr_data), 64'd0);
      check({p, " sum"},     64'(l3 ? b3.sum     : b1.sum),     64'd0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic mon_step(input bit l3);
      logic [21:0] e_rd, a_rd;
      logic [53:0] e_wr, a_wr;
      logic [48:0] e_dn, a_dn;
      int n_rd, n_wr, n_dn;
      string p;
      p    = l3 ? "lat3" : "lat1";
      a_rd = {cyc[15:0], (l3 ? b3.rd_addr : b1.rd_addr)};
      a_wr = {cyc[15:0], (l3 ? b3.wr_addr : b1.wr_addr), (l3 ? b3.wr_data : b1.wr_data)};
      a_dn = {cyc[15:0], (l3 ? b3.aborted : b1.aborted), (l3 ? b3.sum : b1.sum)};
      n_rd = l3 ? exp_rd3.size() : exp_rd1.size();
      n_wr = l3 ? exp_wr3.size() : exp_wr1.size();
      n_dn = l3 ? exp_dn3.size() : exp_dn1.size();
      if (l3 ? b3.rd_cs : b1.rd_cs) begin
         check({p, " read expected"}, 64'(n_rd != 0), 64'd1);
         if (n_rd != 0) begin
            if (l3) e_rd = exp_rd3.pop_front(); else e_rd = exp_rd1.pop_front();
            check({p, " read cycle/addr"}, 64'(a_rd), 64'(e_rd));
         end
      end
      if (l3 ? b3.wr_cs : b1.wr_cs) begin
         check({p, " write expected"}, 64'(n_wr != 0), 64'd1);
         if (n_wr != 0) begin
            if (l3) e_wr = exp_wr3.pop_front(); else e_wr = exp_wr1.pop_front();
            check({p, " write cycle/addr/data"}, 64'(a_wr), 64'(e_wr));
         end
      end
      if (l3 ? b3.done : b1.done) begin
         done_seen[l3]++;
         check({p, " done expected"}, 64'(n_dn != 0), 64'd1);
         check({p, " busy low at done"}, 64'(l3 ? b3.busy : b1.busy), 64'd0);
         if (n_dn != 0) begin
            if (l3) e_dn = exp_dn3.pop_front(); else e_dn = exp_dn1.pop_front();
            check({p, " done cycle/aborted/sum"}, 64'(a_dn), 64'(e_dn));
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         mon_step(1'b0);
         mon_step(1'b1);
      end
   end

   // ---------------- driver ----------------
   task automatic run(input bit l3, input logic [5:0] sb, input logic [5:0] db, input logic [5:0] ln,
                      input logic [1:0] md, input bit ab0, input int ab_at, input int bs_at);
      int t0, n, ne, lat, d0;
      logic [DW-1:0] d, s;
      lat = l3 ? 3 : 1;
      n   = (ln == 6'd0) ? 64 : int'(ln);
      ne  = (ab_at > 0 && ab_at <= n) ? ab_at - 1 : n;
      d0  = done_seen[l3];
      @(posedge clk); #1;
      t0 = cyc;
      s  = '0;
      for (int i = 0; i < ne; i++) begin
         d = src_mem[6'(int'(sb) + i)];
         s = s + d;
         if (l3) exp_rd3.push_back({16'(t0 + 1 + i), 6'(int'(sb) + i)});
         else    exp_rd1.push_back({16'(t0 + 1 + i), 6'(int'(sb) + i)});
         if (md != 2'b11) begin
            if (l3) exp_wr3.push_back({16'(t0 + 2 + i + lat), 6'(int'(db) + i), xf(md, d)});
            else    exp_wr1.push_back({16'(t0 + 2 + i + lat), 6'(int'(db) + i), xf(md, d)});
         end
      end
      if (l3) exp_dn3.push_back({16'(t0 + ne + lat + 2), 1'(ne < n), s});
      else    exp_dn1.push_back({16'(t0 + ne + lat + 2), 1'(ne < n), s});
      drive(l3, 1'b1, ab0, sb, db, ln, md);
      for (int c = 1; c < 300 && done_seen[l3] == d0; c++) begin
         @(posedge clk); #1;
         drive(l3, 1'b0, c == ab_at, sb, db, ln, md);
         if (c == bs_at) begin
            check("busy at ignored start", 64'(l3 ? b3.busy : b1.busy), 64'd1);
            drive(l3, 1'b1, 1'b0, sb + 6'd7, db + 6'd7, 6'd2, 2'b00);
         end
      end
      check("done within budget", 64'(done_seen[l3] != d0), 64'd1);
      if (done_seen[l3] == d0) begin
         exp_rd1.delete(); exp_wr1.delete(); exp_dn1.delete();
         exp_rd3.delete(); exp_wr3.delete(); exp_dn3.delete();
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int t0;
      drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 2'b00);
      drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 2'b00);
      for (int i = 0; i < 64; i++) src_mem[i] = 32'(i);
      repeat (3) @(posedge clk);
      #1;
      chk_idle(1'b0, "reset lat1");
      chk_idle(1'b1, "reset lat3");
      reset = 1'b0;

      // full 64-word copy, len 0
      run(1'b0, 6'h00, 6'h00, 6'd0, 2'b00, 1'b0, 0, 0);
      check("full copy sum", 64'(b1.sum), 64'h7E0);
      check("full copy aborted", 64'(b1.aborted), 64'd0);

      // low-half duplicate across the source wrap; abort with start is ignored
      src_mem[62] = 32'h1234ABCD;
      src_mem[63] = 32'h0F0F5555;
      src_mem[0]  = 32'hFFFF0001;
      src_mem[1]  = 32'h80007FFF;
      run(1'b0, 6'h3E, 6'h10, 6'd4, 2'b01, 1'b1, 0, 0);
      check("dup last wr_data", 64'(b1.wr_data), 64'h7FFF7FFF);
      check("dup last wr_addr", 64'(b1.wr_addr), 64'h13);
      check("dup aborted", 64'(b1.aborted), 64'd0);
      src_mem[62] = 32'd62;
      src_mem[63] = 32'd63;
      src_mem[0]  = 32'd0;
      src_mem[1]  = 32'd1;

      // invert with read latency 3
      run(1'b1, 6'h3C, 6'h00, 6'd5, 2'b10, 1'b0, 0, 0);
      check("inv lat3 sum", 64'(b3.sum), 64'hF6);
      check("inv lat3 last wr_data", 64'(b3.wr_data), 64'hFFFFFFFF);

      // sum only: no writes expected
      run(1'b0, 6'h08, 6'h00, 6'd8, 2'b11, 1'b0, 0, 0);
      check("sum-only sum", 64'(b1.sum), 64'h5C);

      // abort in cycle 4, plus a start while busy in cycle 2
      run(1'b0, 6'h20, 6'h30, 6'd20, 2'b00, 1'b0, 4, 2);
      check("abort aborted", 64'(b1.aborted), 64'd1);
      check("abort sum", 64'(b1.sum), 64'h63);

      // abort during DRAIN has no effect
      run(1'b0, 6'h00, 6'h00, 6'd3, 2'b00, 1'b0, 5, 0);
      check("late abort aborted", 64'(b1.aborted), 64'd0);

      // asynchronous reset mid-ISSUE
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < 4; i++) exp_rd1.push_back({16'(t0 + 1 + i), 6'(i)});
      for (int i = 0; i < 2; i++) exp_wr1.push_back({16'(t0 + 3 + i), 6'(i), 32'(i)});
      drive(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd20, 2'b00);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd20, 2'b00);
      repeat (4) @(posedge clk);
      #3;
      check("busy before reset", 64'(b1.busy), 64'd1);
      reset = 1'b1;
      #1;
      chk_idle(1'b0, "async reset lat1");
      check("fsm idle after reset", 64'(b1.fsm_state), 64'd0);
      exp_rd1.delete(); exp_wr1.delete(); exp_dn1.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      run(1'b0, 6'h05, 6'd40, 6'd6, 2'b10, 1'b0, 0, 0);
      check("post-reset sum", 64'(b1.sum), 64'h2D);

      repeat (3) @(posedge clk);
      #1;
      check("lat1 reads left", 64'(exp_rd1.size()), 64'd0);
      check("lat1 writes left", 64'(exp_wr1.size()), 64'd0);
      check("lat1 dones left", 64'(exp_dn1.size()), 64'd0);
      check("lat3 reads left", 64'(exp_rd3.size()), 64'd0);
      check("lat3 writes left", 64'(exp_wr3.size()), 64'd0);
      check("lat3 dones left", 64'(exp_dn3.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
